// File: rtl/wish_pkg.sv
// Shared definitions for the wishbone pack/unpack blocks.
//   TGC_FIRST / TGC_LAST : bit positions inside the 2-bit cycle tag
//   tgc_t                : 2-bit cycle tag type
//   clamp_cnt()          : maps a raw word count onto 1..num_pack (0 or overflow -> num_pack)
package wish_pkg;

  localparam int unsigned TGC_W     = 2;
  localparam int unsigned TGC_FIRST = 0;
  localparam int unsigned TGC_LAST  = 1;

  typedef logic [TGC_W-1:0] tgc_t;

  // A zero or oversized count means "full beat".
  function automatic int unsigned clamp_cnt(input int unsigned cnt,
                                            input int unsigned num_pack);
    if ((cnt == 0) || (cnt > num_pack)) begin
      return num_pack;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/wish_unpack_slot.sv
// One beat storage slot for the unpacker.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   load_i         : capture dat_i/len_i/tgc_i and mark the slot valid (wins over clear)
//   clear_i        : mark the slot empty
//   dat_o/len_o/tgc_o/valid_o : stored beat and occupancy flag
module wish_unpack_slot
  import wish_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          clear_i,
  input  logic [DW-1:0] dat_i,
  input  logic [CW-1:0] len_i,
  input  tgc_t          tgc_i,
  output logic [DW-1:0] dat_o,
  output logic [CW-1:0] len_o,
  output tgc_t          tgc_o,
  output logic          valid_o
);

  logic [DW-1:0] dat_q, dat_d;
  logic [CW-1:0] len_q, len_d;
  tgc_t          tgc_q, tgc_d;
  logic          valid_q, valid_d;

  // Next-state: load has priority so a release+refill in one cycle keeps the slot full.
  always_comb begin
    dat_d   = dat_q;
    len_d   = len_q;
    tgc_d   = tgc_q;
    valid_d = valid_q;
    if (load_i) begin
      dat_d   = dat_i;
      len_d   = len_i;
      tgc_d   = tgc_i;
      valid_d = 1'b1;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dat_q   <= '0;
      len_q   <= '0;
      tgc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      dat_q   <= dat_d;
      len_q   <= len_d;
      tgc_q   <= tgc_d;
      valid_q <= valid_d;
    end
  end

  assign dat_o   = dat_q;
  assign len_o   = len_q;
  assign tgc_o   = tgc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/wish_unpack_flex.sv
// Wishbone-style width down-converter: one source beat of up to NUM_PACK words
// is emitted one word per destination transfer.
//   clk_i, rst_i                : clock, asynchronous active-high reset
//   s_stb_i, s_cyc_i, s_ack_o, s_stall_o, s_dat_i, s_cnt_i, s_tgc_i : wide source
//   d_stb_o, d_cyc_o, d_ack_i, d_dat_o, d_tgc_o                      : narrow destination
// Build option: WISH_UNPACK_FLEX_REG_ACK_EN defined -> head+tail slots and s_ack_o
// driven from registers only; undefined -> single slot, s_ack_o depends on d_ack_i.
module wish_unpack_flex
  import wish_pkg::*;
#(
  parameter int unsigned   DATA_WIDTH    = 8,
  parameter int unsigned   NUM_PACK      = 4,
  parameter bit            LITTLE_ENDIAN = 1'b1,
  localparam int unsigned  CW            = $clog2(NUM_PACK + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             s_stb_i,
  input  logic                             s_cyc_i,
  output logic                             s_ack_o,
  output logic                             s_stall_o,
  input  logic [DATA_WIDTH*NUM_PACK-1:0]   s_dat_i,
  input  logic [CW-1:0]                    s_cnt_i,
  input  logic [1:0]                       s_tgc_i,
  output logic                             d_stb_o,
  output logic                             d_cyc_o,
  input  logic                             d_ack_i,
  output logic [DATA_WIDTH-1:0]            d_dat_o,
  output logic [1:0]                       d_tgc_o
);

  localparam int unsigned SW = DATA_WIDTH * NUM_PACK;

  logic [SW-1:0]   head_dat, head_dat_in;
  logic [CW-1:0]   head_len, head_len_in;
  tgc_t            head_tgc, head_tgc_in;
  logic            head_valid;
  logic            head_load_c, head_clear_c;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   s_len_c;
  logic            last_c, d_xfer_c, rel_c, s_xfer_c;
  logic [DATA_WIDTH-1:0] word_c;

  assign s_len_c  = CW'(clamp_cnt(32'(s_cnt_i), NUM_PACK));
  assign last_c   = head_valid && (cnt_q == (head_len - CW'(1)));
  assign d_xfer_c = head_valid && d_ack_i;
  assign rel_c    = d_xfer_c && last_c;
  assign s_xfer_c = s_stb_i && s_cyc_i && s_ack_o;

`ifdef WISH_UNPACK_FLEX_REG_ACK_EN
  logic [SW-1:0]   tail_dat;
  logic [CW-1:0]   tail_len;
  tgc_t            tail_tgc;
  logic            tail_valid;
  logic            tail_load_c, tail_clear_c, head_from_tail_c;

  // Acknowledge depends only on tail occupancy (a register).
  assign s_ack_o = !rst_i && !tail_valid;

  // Routing: a released head is refilled from the tail first, else straight from the source.
  always_comb begin
    head_from_tail_c = rel_c && tail_valid;
    head_load_c      = head_from_tail_c || (s_xfer_c && (!head_valid || rel_c));
    head_clear_c     = rel_c && !head_load_c;
    tail_load_c      = s_xfer_c && head_valid && (!rel_c || tail_valid);
    tail_clear_c     = head_from_tail_c && !tail_load_c;
    head_dat_in      = head_from_tail_c ? tail_dat : s_dat_i;
    head_len_in      = head_from_tail_c ? tail_len : s_len_c;
    head_tgc_in      = head_from_tail_c ? tail_tgc : tgc_t'(s_tgc_i);
  end

  wish_unpack_slot #(.DW(SW), .CW(CW)) u_tail (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (tail_load_c),
    .clear_i (tail_clear_c),
    .dat_i   (s_dat_i),
    .len_i   (s_len_c),
    .tgc_i   (tgc_t'(s_tgc_i)),
    .dat_o   (tail_dat),
    .len_o   (tail_len),
    .tgc_o   (tail_tgc),
    .valid_o (tail_valid)
  );
`else
  // Single slot: a new beat may enter only while the head is empty or leaving this cycle.
  assign s_ack_o = !rst_i && (!head_valid || rel_c);

  always_comb begin
    head_load_c  = s_xfer_c;
    head_clear_c = rel_c && !s_xfer_c;
    head_dat_in  = s_dat_i;
    head_len_in  = s_len_c;
    head_tgc_in  = tgc_t'(s_tgc_i);
  end
`endif

  wish_unpack_slot #(.DW(SW), .CW(CW)) u_head (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (head_load_c),
    .clear_i (head_clear_c),
    .dat_i   (head_dat_in),
    .len_i   (head_len_in),
    .tgc_i   (head_tgc_in),
    .dat_o   (head_dat),
    .len_o   (head_len),
    .tgc_o   (head_tgc),
    .valid_o (head_valid)
  );

  // Word index: restarts on every fresh head beat, advances on non-final transfers.
  always_comb begin
    cnt_d = cnt_q;
    if (head_load_c || rel_c) begin
      cnt_d = '0;
    end else if (d_xfer_c) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Word select; big-endian beats count down from the most significant word.
  always_comb begin
    word_c = '0;
    for (int unsigned k = 0; k < NUM_PACK; k++) begin
      if (cnt_q == CW'(k)) begin
        if (LITTLE_ENDIAN) begin
          word_c = head_dat[k*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          word_c = head_dat[(NUM_PACK-1-k)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign s_stall_o          = !rst_i && !s_ack_o;
  assign d_stb_o            = head_valid;
  assign d_cyc_o            = head_valid;
  assign d_dat_o            = word_c;
  assign d_tgc_o[TGC_FIRST] = head_valid && head_tgc[TGC_FIRST] && (cnt_q == '0);
  assign d_tgc_o[TGC_LAST]  = head_tgc[TGC_LAST] && last_c;

endmodule

// File: tb/tb_wish_unpack_flex.sv
// Self-checking bench for wish_unpack_flex: one little-endian and one big-endian
// instance share the stimulus; a scoreboard of expected words is filled on every
// accepted source beat and drained on every destination transfer.
module tb_wish_unpack_flex;

  typedef struct packed {
    logic [7:0] dat;
    logic [1:0] tgc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_stb, s_cyc;
  logic [31:0] s_dat;
  logic [2:0]  s_cnt;
  logic [1:0]  s_tgc;
  logic        d_ack;

  logic        s_ack_le, s_stall_le, d_stb_le, d_cyc_le;
  logic [7:0]  d_dat_le;
  logic [1:0]  d_tgc_le;
  logic        s_ack_be, s_stall_be, d_stb_be, d_cyc_be;
  logic [7:0]  d_dat_be;
  logic [1:0]  d_tgc_be;

  exp_t q_le[$];
  exp_t q_be[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   xfer_cnt = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  bit   s_took;
  logic [31:0] tp [3] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};

  always #5 clk = ~clk;

  wish_unpack_flex #(.DATA_WIDTH(8), .NUM_PACK(4), .LITTLE_ENDIAN(1'b1)) u_le (
    .clk_i(clk), .rst_i(rst), .s_stb_i(s_stb), .s_cyc_i(s_cyc), .s_ack_o(s_ack_le),
    .s_stall_o(s_stall_le), .s_dat_i(s_dat), .s_cnt_i(s_cnt), .s_tgc_i(s_tgc),
    .d_stb_o(d_stb_le), .d_cyc_o(d_cyc_le), .d_ack_i(d_ack), .d_dat_o(d_dat_le),
    .d_tgc_o(d_tgc_le)
  );

  wish_unpack_flex #(.DATA_WIDTH(8), .NUM_PACK(4), .LITTLE_ENDIAN(1'b0)) u_be (
    .clk_i(clk), .rst_i(rst), .s_stb_i(s_stb), .s_cyc_i(s_cyc), .s_ack_o(s_ack_be),
    .s_stall_o(s_stall_be), .s_dat_i(s_dat), .s_cnt_i(s_cnt), .s_tgc_i(s_tgc),
    .d_stb_o(d_stb_be), .d_cyc_o(d_cyc_be), .d_ack_i(d_ack), .d_dat_o(d_dat_be),
    .d_tgc_o(d_tgc_be)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected words of one accepted beat, for both word orders.
  task automatic push_beat(input logic [31:0] dat, input logic [2:0] cnt, input logic [1:0] tgc);
    int   n;
    exp_t e;
    n = ((cnt == 3'd0) || (cnt > 3'd4)) ? 4 : int'(cnt);
    for (int k = 0; k < n; k++) begin
      e.tgc = {tgc[1] && (k == n - 1), tgc[0] && (k == 0)};
      e.dat = dat[k*8 +: 8];
      q_le.push_back(e);
      e.dat = dat[(3-k)*8 +: 8];
      q_be.push_back(e);
    end
  endtask

  // One clock: sample at the falling edge, then return 1 time unit after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    s_took = 1'b0;
    if (rst) begin
      q_le.delete();
      q_be.delete();
    end else begin
      chk("d_cyc_eq_stb", {30'd0, d_cyc_le, d_cyc_be}, {30'd0, d_stb_le, d_stb_be});
      if (d_stb_le && d_ack) begin
        chk("le_word_expected", 32'(q_le.size() > 0), 32'd1);
        if (q_le.size() > 0) begin
          e = q_le.pop_front();
          chk("le_word", {22'd0, d_dat_le, d_tgc_le}, {22'd0, e});
        end
        xfer_cnt++;
        if (xfer_cnt == 1) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (d_stb_be && d_ack) begin
        chk("be_word_expected", 32'(q_be.size() > 0), 32'd1);
        if (q_be.size() > 0) begin
          e = q_be.pop_front();
          chk("be_word", {22'd0, d_dat_be, d_tgc_be}, {22'd0, e});
        end
      end
      if (s_stb && s_cyc && s_ack_le) begin
        push_beat(s_dat, s_cnt, s_tgc);
        s_took = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Run with d_ack high until the pending beat is taken and all words have left.
  task automatic drain(input string tag);
    bit done;
    done  = 1'b0;
    d_ack = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (s_took) s_stb = 1'b0;
      done = !s_stb && (q_le.size() == 0) && (q_be.size() == 0) && !d_stb_le && !d_stb_be;
    end
    chk({tag, "_drained"}, 32'(done), 32'd1);
  endtask

  task automatic send(input logic [31:0] dat, input logic [2:0] cnt, input logic [1:0] tgc,
                      input string tag);
    s_dat = dat;
    s_cnt = cnt;
    s_tgc = tgc;
    s_stb = 1'b1;
    drain(tag);
  endtask

  initial begin
    rst = 1'b1; s_stb = 1'b0; s_cyc = 1'b1; s_dat = '0; s_cnt = '0; s_tgc = '0; d_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_d_stb", {30'd0, d_stb_le, d_stb_be}, 32'd0);
    chk("rst_s_ack", {30'd0, s_ack_le, s_ack_be}, 32'd0);
    chk("rst_s_stall", {30'd0, s_stall_le, s_stall_be}, 32'd0);
    chk("rst_d_tgc", {28'd0, d_tgc_le, d_tgc_be}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_s_ack", {30'd0, s_ack_le, s_ack_be}, 32'd3);
    chk("idle_s_stall", {30'd0, s_stall_le, s_stall_be}, 32'd0);

    // Full beat, both orders.
    send(32'hDDCCBBAA, 3'd4, 2'b11, "full");
    // Partial beat: two words.
    send(32'hDDCCBBAA, 3'd2, 2'b11, "part2");

    // Single word carrying both tags; also probes the acknowledge path from d_ack.
    d_ack = 1'b0; s_dat = 32'hDDCCBBAA; s_cnt = 3'd1; s_tgc = 2'b11; s_stb = 1'b1;
    step();
    chk("one_accept", 32'(s_took), 32'd1);
    s_stb = 1'b0;
    chk("one_dat", {24'd0, d_dat_le}, 32'hAA);
    chk("one_tgc", {30'd0, d_tgc_le}, 32'd3);
`ifdef WISH_UNPACK_FLEX_REG_ACK_EN
    chk("one_sack_noack", {31'd0, s_ack_le}, 32'd1);
`else
    chk("one_sack_noack", {31'd0, s_ack_le}, 32'd0);
`endif
    d_ack = 1'b1;
    #1;
    chk("one_sack_ack", {31'd0, s_ack_le}, 32'd1);
    drain("one");

    // Count clamping.
    send(32'h87654321, 3'd0, 2'b01, "cnt0");
    send(32'hF0E0D0C0, 3'd7, 2'b10, "cnt7");

    // Backpressure on the second word with a second beat waiting.
    d_ack = 1'b0; s_dat = 32'hDDCCBBAA; s_cnt = 3'd4; s_tgc = 2'b11; s_stb = 1'b1;
    step();
    chk("bp_accept", 32'(s_took), 32'd1);
    s_dat = 32'h44332211; s_tgc = 2'b00; d_ack = 1'b1;
    step();
    if (s_took) s_stb = 1'b0;
    d_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_le", {24'd0, d_dat_le}, 32'hBB);
      chk("bp_hold_be", {24'd0, d_dat_be}, 32'hCC);
      chk("bp_tgc", {30'd0, d_tgc_le}, 32'd0);
      chk("bp_sack", {31'd0, s_ack_le}, 32'd0);
`ifdef WISH_UNPACK_FLEX_REG_ACK_EN
      d_ack = 1'b1;
      #1;
      chk("bp_sack_d_ack_hi", {31'd0, s_ack_le}, 32'd0);
      d_ack = 1'b0;
`endif
      step();
    end
    drain("bp");

    // Throughput: three full beats back to back.
    xfer_cnt = 0; d_ack = 1'b1; s_cnt = 3'd4; s_tgc = 2'b01; s_dat = tp[0]; s_stb = 1'b1;
    begin
      int idx;
      idx = 0;
      for (int i = 0; i < 40 && xfer_cnt < 12; i++) begin
        step();
        if (s_took) begin
          idx++;
          if (idx < 3) begin
            s_dat = tp[idx];
            s_tgc = (idx == 2) ? 2'b10 : 2'b00;
          end else begin
            s_stb = 1'b0;
          end
        end
      end
    end
    chk("tp_words", 32'(xfer_cnt), 32'd12);
    chk("tp_span", 32'(last_cyc - first_cyc), 32'd11);
    drain("tp");

    // Reset in the middle of a beat.
    d_ack = 1'b1; s_dat = 32'hDDCCBBAA; s_cnt = 3'd4; s_tgc = 2'b11; s_stb = 1'b1;
    step();
    chk("rb_accept", 32'(s_took), 32'd1);
    s_stb = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_d_stb", {30'd0, d_stb_le, d_stb_be}, 32'd0);
    chk("mid_rst_s_ack", {30'd0, s_ack_le, s_stall_le}, 32'd0);
    chk("mid_rst_d_tgc", {28'd0, d_tgc_le, d_tgc_be}, 32'd0);
    step();
    step();
    rst = 1'b0;
    send(32'h44332211, 3'd4, 2'b11, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
